// File: rtl/dma_priority_arbiter_if.sv
// dma_priority_arbiter_if: request qualification inputs and grant outputs between DMA pins, command register and timing control
interface dma_priority_arbiter_if #(parameter int NCH = 4);
  logic [NCH-1:0] DREQ;
  logic [NCH-1:0] maskReg;
  logic [NCH-1:0] requestReg;
  logic ctrlDisable;
  logic rotatePri;
  logic dreqSenseLow;
  logic dackSenseHigh;
  logic HLDA;
  logic cycleDone;
  logic [NCH-1:0] VALID_DREQ;
  logic [NCH-1:0] DACK;
  logic [1:0] grantId;
  logic busy;
  logic [NCH-1:0] pendingReq;
  modport slave (
    input DREQ, maskReg, requestReg, ctrlDisable, rotatePri, dreqSenseLow, dackSenseHigh, HLDA, cycleDone,
    output VALID_DREQ, DACK, grantId, busy, pendingReq
  );
  modport master (
    output DREQ, maskReg, requestReg, ctrlDisable, rotatePri, dreqSenseLow, dackSenseHigh, HLDA, cycleDone,
    input VALID_DREQ, DACK, grantId, busy, pendingReq
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: qualifies DREQs, picks one channel by fixed/rotating priority and holds the grant until service ends
module dma_priority_arbiter (
  input logic CLK,
  input logic RESET,
  dma_priority_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, SERVICE, RELEASE} state_t;
  state_t state;
  logic [3:0] hw_req, req_eff, rot, valid, dack_active;
  logic [1:0] top_pri, pri, off, win_id, grant_id;
  assign hw_req = bus.DREQ ^ {4{bus.dreqSenseLow}};
  assign req_eff = (hw_req & ~bus.maskReg) | bus.requestReg;
  // rotate requests so the top-priority channel sits at bit 0, then take the first set bit
  always_comb begin
    pri = bus.rotatePri ? top_pri : 2'd0;
    rot = 4'({req_eff, req_eff} >> pri);
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    win_id = pri + off;
  end
  // grant FSM: latch winner, hold through service, rotate priority only on completed service
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      valid <= '0;
      dack_active <= '0;
      grant_id <= '0;
      top_pri <= '0;
    end else begin
      if (!bus.rotatePri) top_pri <= '0;
      case (state)
        IDLE: if (!bus.ctrlDisable && |req_eff) begin
          state <= GRANT;
          valid <= 4'b0001 << win_id;
          grant_id <= win_id;
        end
        GRANT: if (bus.HLDA) begin
          state <= SERVICE;
          dack_active <= valid;
        end else if (!req_eff[grant_id]) begin
          state <= IDLE;
          valid <= '0;
        end
        SERVICE: if (bus.cycleDone) begin
          state <= RELEASE;
          valid <= '0;
          dack_active <= '0;
          if (bus.rotatePri) top_pri <= grant_id + 2'd1;
        end else if (!bus.HLDA) begin
          state <= IDLE;
          valid <= '0;
          dack_active <= '0;
        end
        RELEASE: state <= IDLE;
      endcase
    end
  end
  // status view of raw requests, mask ignored
  always_ff @(posedge CLK) begin
    if (RESET) bus.pendingReq <= '0;
    else bus.pendingReq <= hw_req | bus.requestReg;
  end
  assign bus.VALID_DREQ = valid;
  assign bus.grantId = grant_id;
  assign bus.busy = state != IDLE;
  assign bus.DACK = dack_active ^ {4{~bus.dackSenseHigh}};
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb_dma_priority_arbiter: scoreboard-driven checks of priority, masking, polarity, withdraw/abort, reset and disable
module tb_dma_priority_arbiter;
  logic clk = 0;
  logic rst;
  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];
  logic [3:0] e, v;
  dma_priority_arbiter_if bus ();
  dma_priority_arbiter dut (.CLK(clk), .RESET(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    bus.DREQ = 0; bus.maskReg = 0; bus.requestReg = 0; bus.ctrlDisable = 0; bus.rotatePri = 0;
    bus.dreqSenseLow = 0; bus.dackSenseHigh = 0; bus.HLDA = 0; bus.cycleDone = 0;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = 0;
    for (int i = 0; i < 6 && g == 0; i++) begin
      tick();
      g = bus.VALID_DREQ;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.VALID_DREQ !== 4'b0000) begin fails++; $display("FAIL reset_valid got=%b exp=0000", bus.VALID_DREQ); end
    tests++; if (bus.DACK !== 4'b1111) begin fails++; $display("FAIL reset_dack got=%b exp=1111", bus.DACK); end
    tests++; if (bus.grantId !== 2'd0) begin fails++; $display("FAIL reset_grant_id got=%0d exp=0", bus.grantId); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    tests++; if (bus.pendingReq !== 4'b0000) begin fails++; $display("FAIL reset_pending got=%b exp=0000", bus.pendingReq); end
  endtask

  task automatic test_fixed();
    do_reset();
    bus.DREQ = 4'b1010;
    exp_q.push_back(4'b0010);
    tick();
    e = exp_q.pop_front();
    tests++; if (bus.VALID_DREQ !== e) begin fails++; $display("FAIL fixed_grant1 got=%b exp=%b", bus.VALID_DREQ, e); end
    tests++; if (bus.grantId !== 2'd1) begin fails++; $display("FAIL fixed_id1 got=%0d exp=1", bus.grantId); end
    tick();
    tests++; if (bus.VALID_DREQ !== 4'b0010 || bus.DACK !== 4'b1111) begin fails++; $display("FAIL fixed_hold got=%b/%b exp=0010/1111", bus.VALID_DREQ, bus.DACK); end
    bus.HLDA = 1;
    tick();
    tests++; if (bus.DACK !== 4'b1101) begin fails++; $display("FAIL fixed_dack got=%b exp=1101", bus.DACK); end
    bus.cycleDone = 1; bus.HLDA = 0; bus.DREQ = 4'b1000;
    tick();
    bus.cycleDone = 0;
    tests++; if (bus.VALID_DREQ !== 4'b0000 || bus.DACK !== 4'b1111) begin fails++; $display("FAIL fixed_release got=%b/%b exp=0000/1111", bus.VALID_DREQ, bus.DACK); end
    exp_q.push_back(4'b1000);
    tick();
    tests++; if (bus.VALID_DREQ !== 4'b0000) begin fails++; $display("FAIL fixed_gap got=%b exp=0000", bus.VALID_DREQ); end
    tick();
    e = exp_q.pop_front();
    tests++; if (bus.VALID_DREQ !== e) begin fails++; $display("FAIL fixed_grant2 got=%b exp=%b", bus.VALID_DREQ, e); end
    tests++; if (bus.grantId !== 2'd3) begin fails++; $display("FAIL fixed_id2 got=%0d exp=3", bus.grantId); end
  endtask

  task automatic test_rotate();
    do_reset();
    bus.rotatePri = 1;
    bus.DREQ = 4'b0010;
    exp_q.push_back(4'b0010);
    tick();
    e = exp_q.pop_front();
    tests++; if (bus.VALID_DREQ !== e) begin fails++; $display("FAIL rot_first got=%b exp=%b", bus.VALID_DREQ, e); end
    bus.HLDA = 1;
    tick();
    bus.cycleDone = 1; bus.HLDA = 0; bus.DREQ = 4'b1111;
    tick();
    bus.cycleDone = 0;
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    for (int k = 0; k < 5; k++) begin
      wait_grant(v);
      e = exp_q.pop_front();
      tests++; if (v !== e) begin fails++; $display("FAIL rot_order%0d got=%b exp=%b", k, v, e); end
      if (k < 4) begin
        bus.HLDA = 1;
        tick();
        bus.cycleDone = 1; bus.HLDA = 0;
        tick();
        bus.cycleDone = 0;
      end
    end
  endtask

  task automatic test_mask_swreq();
    do_reset();
    bus.maskReg = 4'b0001; bus.DREQ = 4'b0001;
    tick();
    tick();
    tests++; if (bus.VALID_DREQ !== 4'b0000 || bus.busy !== 1'b0) begin fails++; $display("FAIL mask_block got=%b busy=%b exp=0000 busy=0", bus.VALID_DREQ, bus.busy); end
    tests++; if (bus.pendingReq !== 4'b0001) begin fails++; $display("FAIL mask_pending got=%b exp=0001", bus.pendingReq); end
    bus.requestReg = 4'b0001;
    exp_q.push_back(4'b0001);
    tick();
    e = exp_q.pop_front();
    tests++; if (bus.VALID_DREQ !== e) begin fails++; $display("FAIL swreq_grant got=%b exp=%b", bus.VALID_DREQ, e); end
  endtask

  task automatic test_polarity();
    do_reset();
    bus.dreqSenseLow = 1; bus.dackSenseHigh = 1; bus.DREQ = 4'b1110;
    exp_q.push_back(4'b0001);
    tick();
    e = exp_q.pop_front();
    tests++; if (bus.VALID_DREQ !== e) begin fails++; $display("FAIL pol_grant got=%b exp=%b", bus.VALID_DREQ, e); end
    tests++; if (bus.DACK !== 4'b0000 || bus.pendingReq !== 4'b0001) begin fails++; $display("FAIL pol_idle_dack got=%b pend=%b exp=0000 pend=0001", bus.DACK, bus.pendingReq); end
    bus.HLDA = 1;
    tick();
    tests++; if (bus.DACK !== 4'b0001) begin fails++; $display("FAIL pol_dack got=%b exp=0001", bus.DACK); end
    bus.cycleDone = 1; bus.HLDA = 0; bus.DREQ = 4'b1111;
    tick();
    bus.cycleDone = 0;
    tests++; if (bus.DACK !== 4'b0000 || bus.VALID_DREQ !== 4'b0000) begin fails++; $display("FAIL pol_done got=%b/%b exp=0000/0000", bus.DACK, bus.VALID_DREQ); end
  endtask

  task automatic test_withdraw_abort();
    do_reset();
    bus.rotatePri = 1;
    bus.DREQ = 4'b0100;
    exp_q.push_back(4'b0100);
    tick();
    e = exp_q.pop_front();
    tests++; if (bus.VALID_DREQ !== e) begin fails++; $display("FAIL wd_grant got=%b exp=%b", bus.VALID_DREQ, e); end
    bus.DREQ = 4'b0000;
    tick();
    tests++; if (bus.VALID_DREQ !== 4'b0000 || bus.busy !== 1'b0 || bus.DACK !== 4'b1111) begin fails++; $display("FAIL wd_idle got=%b busy=%b dack=%b exp=0000 busy=0 dack=1111", bus.VALID_DREQ, bus.busy, bus.DACK); end
    bus.DREQ = 4'b1111;
    exp_q.push_back(4'b0001);
    tick();
    e = exp_q.pop_front();
    tests++; if (bus.VALID_DREQ !== e) begin fails++; $display("FAIL wd_toppri got=%b exp=%b", bus.VALID_DREQ, e); end
    bus.HLDA = 1;
    tick();
    tests++; if (bus.DACK !== 4'b1110) begin fails++; $display("FAIL abort_dack got=%b exp=1110", bus.DACK); end
    bus.HLDA = 0;
    tick();
    tests++; if (bus.VALID_DREQ !== 4'b0000 || bus.DACK !== 4'b1111 || bus.busy !== 1'b0) begin fails++; $display("FAIL abort_idle got=%b dack=%b busy=%b exp=0000 dack=1111 busy=0", bus.VALID_DREQ, bus.DACK, bus.busy); end
    exp_q.push_back(4'b0001);
    tick();
    e = exp_q.pop_front();
    tests++; if (bus.VALID_DREQ !== e) begin fails++; $display("FAIL abort_toppri got=%b exp=%b", bus.VALID_DREQ, e); end
  endtask

  task automatic test_reset_disable();
    logic seen;
    do_reset();
    bus.DREQ = 4'b0010;
    tick();
    bus.HLDA = 1;
    tick();
    rst = 1;
    tick();
    rst = 0;
    tests++; if (bus.VALID_DREQ !== 4'b0000 || bus.DACK !== 4'b1111 || bus.grantId !== 2'd0 || bus.busy !== 1'b0 || bus.pendingReq !== 4'b0000) begin fails++; $display("FAIL rst_service got=%b dack=%b id=%0d busy=%b pend=%b", bus.VALID_DREQ, bus.DACK, bus.grantId, bus.busy, bus.pendingReq); end
    bus.HLDA = 0;
    bus.DREQ = 4'b0001;
    exp_q.push_back(4'b0001);
    tick();
    e = exp_q.pop_front();
    tests++; if (bus.VALID_DREQ !== e) begin fails++; $display("FAIL dis_grant got=%b exp=%b", bus.VALID_DREQ, e); end
    bus.HLDA = 1;
    tick();
    bus.ctrlDisable = 1; bus.DREQ = 4'b1111;
    tick();
    tests++; if (bus.DACK !== 4'b1110 || bus.VALID_DREQ !== 4'b0001) begin fails++; $display("FAIL dis_hold got=%b dack=%b exp=0001 dack=1110", bus.VALID_DREQ, bus.DACK); end
    bus.cycleDone = 1; bus.HLDA = 0;
    tick();
    bus.cycleDone = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.VALID_DREQ !== 4'b0000) seen = 1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL dis_block got=%b exp=0", seen); end
    bus.ctrlDisable = 0;
    exp_q.push_back(4'b0001);
    wait_grant(v);
    e = exp_q.pop_front();
    tests++; if (v !== e) begin fails++; $display("FAIL dis_resume got=%b exp=%b", v, e); end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rotate();
    test_mask_swreq();
    test_polarity();
    test_withdraw_abort();
    test_reset_disable();
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
